// File: rtl/lfsr_dither_gen_pkg.sv
// Shared constants for the FOD dither LFSRs: maximal-length tap pairs for
// common register lengths and the all-ones (XNOR lock-up) helper.
package lfsr_dither_gen_pkg;

  typedef struct packed {
    logic [5:0] tap_a;
    logic [5:0] tap_b;
  } tap_pair_t;

  localparam tap_pair_t TAPS_9  = '{tap_a: 6'd9,  tap_b: 6'd5};
  localparam tap_pair_t TAPS_15 = '{tap_a: 6'd15, tap_b: 6'd14};
  localparam tap_pair_t TAPS_23 = '{tap_a: 6'd23, tap_b: 6'd18};
  localparam tap_pair_t TAPS_31 = '{tap_a: 6'd31, tap_b: 6'd28};

  localparam int SYNC_STAGES = 3;

  // All-ones pattern of the given width, right-aligned in 32 bits.
  function automatic logic [31:0] all_ones(int unsigned width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/sync_rst_gen.sv
// Reset synchroniser: asynchronous assertion, release after STAGES clock
// edges. Shared by the FOD blocks.
module sync_rst_gen
  import lfsr_dither_gen_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic CLK,
  input  logic NARST,
  output logic NRST
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour.
  always_ff @(posedge CLK or negedge NARST) begin
    if (!NARST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end
  end

  assign NRST = sync_q[STAGES-1];

endmodule

// File: rtl/lfsr_dither_gen.sv
// Fibonacci XNOR-LFSR dither source: uniform word, thermometer code,
// sequence-wrap flag, runtime seed load with all-ones seed rejection.
module lfsr_dither_gen
  import lfsr_dither_gen_pkg::*;
#(
  parameter int          LFSR_W = 9,
  parameter int          TAP_A  = 9,
  parameter int          TAP_B  = 5,
  parameter int          OUT_W  = 6,
  parameter int unsigned SEED   = 1
) (
  input  logic                   CLK,
  input  logic                   NARST,
  input  logic                   EN,
  input  logic                   HOLD,
  input  logic                   LOAD,
  input  logic [LFSR_W-1:0]      SEED_IN,
  output logic [OUT_W-1:0]       URN,
  output logic [(1<<OUT_W)-1:0]  URNT,
  output logic                   URN_VLD,
  output logic                   WRAP,
  output logic                   LOCKUP
);

  localparam int                URNT_W   = 1 << OUT_W;
  localparam logic [31:0]       ONES32   = all_ones(LFSR_W);
  localparam logic [31:0]       SEED32   = SEED;
  localparam logic [LFSR_W:1]   ONES     = ONES32[LFSR_W-1:0];
  localparam logic [LFSR_W:1]   SEED_V   = SEED32[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] CNT_LAST = ONES32[LFSR_W-1:0] - LFSR_W'(1);

  logic                  nrst;
  logic [LFSR_W:1]       state;
  logic [LFSR_W:1]       seed_reg;
  logic [LFSR_W-1:0]     step_cnt;
  logic                  fb;
  logic [LFSR_W:1]       state_step;
  logic                  seed_in_bad;
  logic [URNT_W-1:0]     urnt_next;

  sync_rst_gen #(.STAGES(SYNC_STAGES)) u_sync_rst (
    .CLK   (CLK),
    .NARST (NARST),
    .NRST  (nrst)
  );

  assign fb          = state[TAP_A] ~^ state[TAP_B];
  assign state_step  = {state[LFSR_W-1:1], fb};
  assign seed_in_bad = (SEED_IN == ONES);

  // NOTE: combinational outputs get a default before the loop so no
  // path through the block leaves a bit unassigned (no latch).
  always_comb begin
    urnt_next = '0;
    for (int unsigned k = 0; k < URNT_W; k++) begin
      urnt_next[k] = (k < 32'(state[OUT_W:1]));
    end
  end

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      state    <= SEED_V;
      seed_reg <= SEED_V;
      step_cnt <= '0;
      URN      <= '0;
      URNT     <= '0;
      URN_VLD  <= 1'b0;
      WRAP     <= 1'b0;
      LOCKUP   <= 1'b0;
    end else begin
      WRAP   <= 1'b0;
      LOCKUP <= 1'b0;
      if (LOAD) begin
        // An all-ones seed would freeze the XNOR register forever.
        if (seed_in_bad) begin
          state    <= SEED_V;
          seed_reg <= SEED_V;
          LOCKUP   <= 1'b1;
        end else begin
          state    <= SEED_IN;
          seed_reg <= SEED_IN;
        end
        step_cnt <= '0;
        URN_VLD  <= 1'b0;
      end else if (!EN) begin
        state    <= seed_reg;
        step_cnt <= '0;
        URN      <= '0;
        URNT     <= '0;
        URN_VLD  <= 1'b0;
      end else if (HOLD) begin
        URN_VLD <= 1'b0;
      end else begin
        URN     <= state[OUT_W:1];
        URNT    <= urnt_next;
        URN_VLD <= 1'b1;
        state   <= state_step;
        if (step_cnt == CNT_LAST) begin
          step_cnt <= '0;
          WRAP     <= 1'b1;
        end else begin
          step_cnt <= step_cnt + LFSR_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/lfsr_dither_gen.md
Name: lfsr_dither_gen

Overview:
Parametrised Fibonacci XNOR-LFSR uniform random number source for DSM dither in the FOD datapath. It generalises the fixed 9-bit / 6-bit dither generator with configurable register length, taps, output width and seed. It adds:
- runtime seed load and hold (freeze);
- a true thermometer output;
- a sequence-wrap flag, plus lock-up protection on seed load.

Parameters:
LFSR_W, 9, LFSR length in bits (state indexed [LFSR_W:1]), range 3..32
TAP_A, 9, first feedback tap index (normally LFSR_W)
TAP_B, 5, second feedback tap index, 1 <= TAP_B < TAP_A
OUT_W, 6, random word width taken from state[OUT_W:1], OUT_W <= LFSR_W, OUT_W <= 8
SEED, 1, reset/restart state; must not be all-ones

Ports:
CLK  in  1  clock
NARST  in  1  asynchronous active-low reset; synchronised internally before use
EN  in  1  1 = run; 0 = restart state to current seed, outputs forced 0
HOLD  in  1  1 = freeze state and outputs (EN must be 1 for effect)
LOAD  in  1  one-cycle strobe: load SEED_IN into state and seed register
SEED_IN  in  LFSR_W  seed value captured on LOAD
URN  out  OUT_W  registered uniform random word
URNT  out  2**OUT_W  registered thermometer code of URN
URN_VLD  out  1  registered, 1 when URN/URNT carry a fresh step
WRAP  out  1  one-cycle pulse when the step counter completes 2**LFSR_W-1 steps
LOCKUP  out  1  one-cycle pulse when an all-ones SEED_IN is rejected

Behaviour:
Reset synchronisation:
- NARST low asynchronously clears a 3-flop synchroniser; internal NRST rises on the 3rd CLK edge after NARST rises.
- All state below resets on NRST low:
  - state = SEED, seed_reg = SEED, step_cnt = 0;
  - URN = 0, URNT = 0, URN_VLD = 0, WRAP = 0, LOCKUP = 0.

Feedback:
- fb = state[TAP_A] XNOR state[TAP_B].
- Step: state <= {state[LFSR_W-1:1], fb}.

Per-cycle priority (out of reset):
1. LOAD=1:
   - SEED_IN all-ones: state <= SEED, seed_reg <= SEED, LOCKUP pulses next cycle.
   - Otherwise: state <= SEED_IN, seed_reg <= SEED_IN.
   - In both cases: step_cnt <= 0, URN_VLD <= 0, URN/URNT hold.
2. EN=0: state <= seed_reg, step_cnt <= 0, URN <= 0, URNT <= 0, URN_VLD <= 0.
3. HOLD=1: state, step_cnt, URN and URNT hold; URN_VLD <= 0.
4. Otherwise (run):
   - URN <= state[OUT_W:1] (pre-step value; 1-cycle latency);
   - URNT[k] <= (k < state[OUT_W:1]) for k = 0..2**OUT_W-1;
   - URN_VLD <= 1; state steps.

Step counter:
- step_cnt is LFSR_W bits wide and increments on each run step.
- On the step where step_cnt == 2**LFSR_W-2: step_cnt <= 0 and WRAP pulses the following cycle. For maximal-length taps, state equals seed_reg again at that point.

Boundary cases:
- An all-ones state is the XNOR lock-up state. It can only arise through SEED_IN, and that path is blocked on load.
- EN falling mid-sequence restarts from seed_reg on the next EN rise; the first URN after the rise equals seed_reg[OUT_W:1].
- NARST assertion mid-run clears everything asynchronously. A loaded seed is lost; the block returns to the SEED parameter.
- URNT with URN=0 is all zeros; URN=2**OUT_W-1 gives all ones except the MSB.

Decomposition:
- Shared package: LFSR tap constants for common lengths (e.g. 9:{9,5}, 15:{15,14}, 23:{23,18}, 31:{31,28}) and a helper function returning all-ones of width LFSR_W.
- Sub-module: reset synchroniser sync_rst_gen (CLK, NARST -> NRST, 3 flops). It is reused by other FOD blocks.

Test Plan:
1. Defaults: release NARST, EN=1 -> NRST high after 3 edges; URN sequence 1,3,7,15,31,62 on consecutive cycles, URN_VLD=1 from the first output.
2. Defaults, run 511 steps -> WRAP pulses exactly once; next URN = 1; state equals seed 1; no repeat within 511 steps (scoreboard all 511 states distinct).
3. LOAD with SEED_IN=9'h1FF -> LOCKUP pulse; state=1. LOAD with 9'h0A5 -> next URN = 6'h25, step_cnt restarted (WRAP 511 steps later).
4. HOLD high for 4 cycles mid-run -> URN/URNT frozen, URN_VLD=0; on release, sequence resumes with no skipped state.
5. EN low mid-run -> URN=0 and URNT=0 next cycle; EN high -> URN restarts at seed_reg[OUT_W:1].
6. URNT check for URN=0, 1, 37, 63 -> popcount(URNT) equals URN. Assert NARST mid-run -> all outputs 0 immediately.
